// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// stage-buffer state encoding and per-stage bundle widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Control/data bundle widths used by each inter-stage register instance.
    localparam int IFID_CTRL_W  = 4;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 16;
    localparam int IDEX_DATA_W  = 128;
    localparam int EXMEM_CTRL_W = 8;
    localparam int EXMEM_DATA_W = 112;
    localparam int MEMWB_CTRL_W = 4;
    localparam int MEMWB_DATA_W = 72;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used to record back-pressure cycles for debug.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Generic pipeline stage register: control + data bundles with valid/ready,
// hazard stall, flush-to-bubble, optional skid entry and a hold-cycle counter.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = 16,
    parameter int DATA_W     = 128,
    parameter int SKID       = 0,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_hold_cnt
);

    pipe_state_t       state_reg, state_next;
    logic [CTRL_W-1:0] head_ctrl_reg, head_ctrl_next;
    logic [DATA_W-1:0] head_data_reg, head_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;
    logic              head_valid;
    logic              in_xfer;
    logic              out_xfer;
    logic              hold_inc;

    assign head_valid = (state_reg != EMPTY);

    // With a skid entry, ready depends only on state and stall, never on i_ready.
    generate
        if (SKID != 0) begin : g_ready_skid
            assign o_ready = !i_stall && (state_reg != FULL);
        end else begin : g_ready_flat
            assign o_ready = !i_stall && (!head_valid || i_ready);
        end
    endgenerate

    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = head_valid && i_ready && !i_stall;

    always_comb begin
        state_next     = state_reg;
        head_ctrl_next = head_ctrl_reg;
        head_data_next = head_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;
        if (i_flush) begin
            state_next     = EMPTY;
            head_ctrl_next = '0;
            skid_ctrl_next = '0;
            if (CLEAR_DATA != 0) begin
                head_data_next = '0;
                skid_data_next = '0;
            end
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_xfer) begin
                        state_next     = ONE;
                        head_ctrl_next = i_ctrl;
                        head_data_next = i_data;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_ctrl_next = i_ctrl;
                        head_data_next = i_data;
                    end else if (in_xfer && (SKID != 0)) begin
                        // Head is blocked: park the new entry behind it.
                        state_next     = FULL;
                        skid_ctrl_next = i_ctrl;
                        skid_data_next = i_data;
                    end else if (out_xfer) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_next     = ONE;
                        head_ctrl_next = skid_ctrl_reg;
                        head_data_next = skid_data_reg;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= EMPTY;
            head_ctrl_reg <= '0;
            head_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            head_ctrl_reg <= head_ctrl_next;
            head_data_reg <= head_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
        end
    end

    // Bubble: control reads as a NOP whenever the head is not valid.
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_bubble
            assign o_ctrl[gi] = head_ctrl_reg[gi] & head_valid;
        end
    endgenerate

    assign o_valid = head_valid;
    assign o_data  = head_data_reg;

    // The flush cycle itself is not counted as a hold.
    assign hold_inc = head_valid && !out_xfer && !i_flush;

    pipe_sat_counter #(
        .CNT_W(CNT_W)
    ) u_hold_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (hold_inc),
        .cnt  (o_hold_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench: a SKID=1/CNT_W=4 instance and a SKID=0 instance share stimulus.
module tb_pipe_stage_buffer;
    import pipe_pkg::*;

    localparam int CW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset, flush, stall, valid, rdy;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;

    logic          a_ready, a_valid, b_ready, b_valid;
    logic [CW-1:0] a_ctrl, b_ctrl;
    logic [DW-1:0] a_data, b_data;
    logic [3:0]    a_cnt;
    logic [15:0]   b_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .i_flush(flush), .i_stall(stall), .i_valid(valid),
        .o_ready(a_ready), .i_ctrl(ctrl), .i_data(data), .o_valid(a_valid),
        .i_ready(rdy), .o_ctrl(a_ctrl), .o_data(a_data), .o_hold_cnt(a_cnt)
    );

    pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLEAR_DATA(1), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .i_flush(flush), .i_stall(stall), .i_valid(valid),
        .o_ready(b_ready), .i_ctrl(ctrl), .i_data(data), .o_valid(b_valid),
        .i_ready(rdy), .o_ctrl(b_ctrl), .o_data(b_data), .o_hold_cnt(b_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; stall = 1'b0; valid = 1'b0; rdy = 1'b0; ctrl = '0; data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_cmp++; if (a_valid !== 1'b0 || a_ctrl !== '0 || a_data !== '0 || a_cnt !== '0) begin
            n_err++; $display("FAIL reset_a: valid=%b ctrl=%h data=%h cnt=%0d required 0/0/0/0", a_valid, a_ctrl, a_data, a_cnt); end
        n_cmp++; if (b_valid !== 1'b0 || b_ctrl !== '0 || b_data !== '0 || b_cnt !== '0) begin
            n_err++; $display("FAIL reset_b: valid=%b ctrl=%h data=%h cnt=%0d required 0/0/0/0", b_valid, b_ctrl, b_data, b_cnt); end
        reset = 1'b0;
        #1;
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: a=%b b=%b required 1/1", a_ready, b_ready); end
        $display("test_reset done");
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        rdy = 1'b1; valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            ctrl = CW'(k); data = {8'hD0, 8'(k)};
            tick();
        end
        rdy = 1'b0; valid = 1'b0;
        tick();
        n_cmp++; if (a_cnt !== 4'd1 || a_ctrl !== 8'd3) begin
            n_err++; $display("FAIL pre_reset_a: cnt=%0d ctrl=%h required 1/03", a_cnt, a_ctrl); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (a_valid !== 1'b0 || a_ctrl !== '0 || a_cnt !== '0) begin
            n_err++; $display("FAIL async_reset_a: valid=%b ctrl=%h cnt=%0d required 0/0/0", a_valid, a_ctrl, a_cnt); end
        n_cmp++; if (b_valid !== 1'b0 || b_ctrl !== '0 || b_cnt !== '0) begin
            n_err++; $display("FAIL async_reset_b: valid=%b ctrl=%h cnt=%0d required 0/0/0", b_valid, b_ctrl, b_cnt); end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_err++; $display("FAIL release_ready: a=%b b=%b required 1/1", a_ready, b_ready); end
        $display("test_reset_mid_stream done");
    endtask

    task automatic test_streaming();
        do_reset();
        rdy = 1'b1; valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            ctrl = CW'(k); data = {8'hD0, 8'(k)};
            #1;
            n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
                n_err++; $display("FAIL stream_ready k=%0d: a=%b b=%b required 1/1", k, a_ready, b_ready); end
            tick();
            n_cmp++; if (a_valid !== 1'b1 || a_ctrl !== CW'(k) || a_data !== {8'hD0, 8'(k)}) begin
                n_err++; $display("FAIL stream_a k=%0d: valid=%b ctrl=%h data=%h required 1/%h/%h", k, a_valid, a_ctrl, a_data, CW'(k), {8'hD0, 8'(k)}); end
            n_cmp++; if (b_valid !== 1'b1 || b_ctrl !== CW'(k) || b_data !== {8'hD0, 8'(k)}) begin
                n_err++; $display("FAIL stream_b k=%0d: valid=%b ctrl=%h data=%h required 1/%h/%h", k, b_valid, b_ctrl, b_data, CW'(k), {8'hD0, 8'(k)}); end
            $display("stream k=%0d a_ctrl=%h b_ctrl=%h", k, a_ctrl, b_ctrl);
        end
        valid = 1'b0;
        tick();
        n_cmp++; if (a_valid !== 1'b0 || a_ctrl !== '0 || a_cnt !== '0) begin
            n_err++; $display("FAIL stream_end_a: valid=%b ctrl=%h cnt=%0d required 0/0/0", a_valid, a_ctrl, a_cnt); end
        n_cmp++; if (b_valid !== 1'b0 || b_ctrl !== '0 || b_cnt !== '0) begin
            n_err++; $display("FAIL stream_end_b: valid=%b ctrl=%h cnt=%0d required 0/0/0", b_valid, b_ctrl, b_cnt); end
    endtask

    // Loads 0xA into the head and 0xB into the skid entry of dut_a.
    task automatic fill_to_full();
        rdy = 1'b0; valid = 1'b1;
        ctrl = 8'h0A; data = 16'hAAAA;
        tick();
        n_cmp++; if (a_ready !== 1'b1 || a_ctrl !== 8'h0A) begin
            n_err++; $display("FAIL one_ready: ready=%b ctrl=%h required 1/0a", a_ready, a_ctrl); end
        ctrl = 8'h0B; data = 16'hBBBB;
        tick();
        valid = 1'b0;
        #1;
        n_cmp++; if (dut_a.state_reg !== FULL || a_ready !== 1'b0) begin
            n_err++; $display("FAIL full_state: state=%0d ready=%b required 2/0", dut_a.state_reg, a_ready); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        fill_to_full();
        tick();
        n_cmp++; if (a_valid !== 1'b1 || a_ctrl !== 8'h0A || a_cnt !== 4'd2) begin
            n_err++; $display("FAIL bp_hold: valid=%b ctrl=%h cnt=%0d required 1/0a/2", a_valid, a_ctrl, a_cnt); end
        rdy = 1'b1;
        tick();
        n_cmp++; if (a_valid !== 1'b1 || a_ctrl !== 8'h0B || a_data !== 16'hBBBB) begin
            n_err++; $display("FAIL bp_second: valid=%b ctrl=%h data=%h required 1/0b/bbbb", a_valid, a_ctrl, a_data); end
        tick();
        n_cmp++; if (a_valid !== 1'b0 || a_cnt !== 4'd2) begin
            n_err++; $display("FAIL bp_drain: valid=%b cnt=%0d required 0/2", a_valid, a_cnt); end
        $display("test_back_pressure done");
    endtask

    task automatic test_flush_priority();
        logic [3:0] cnt_before;
        do_reset();
        fill_to_full();
        cnt_before = a_cnt;
        n_cmp++; if (cnt_before !== 4'd1) begin
            n_err++; $display("FAIL flush_pre_cnt: cnt=%0d required 1", cnt_before); end
        flush = 1'b1; valid = 1'b1; stall = 1'b1; ctrl = 8'h0C; data = 16'hCCCC;
        tick();
        n_cmp++; if (a_valid !== 1'b0 || a_ctrl !== '0 || a_data !== '0 || a_cnt !== 4'd1) begin
            n_err++; $display("FAIL flush_bubble: valid=%b ctrl=%h data=%h cnt=%0d required 0/0/0/1", a_valid, a_ctrl, a_data, a_cnt); end
        flush = 1'b0; stall = 1'b0; valid = 1'b0; rdy = 1'b1;
        tick();
        tick();
        n_cmp++; if (a_valid !== 1'b0 || a_ctrl !== '0 || a_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_no_ghost: valid=%b ctrl=%h ready=%b required 0/0/1", a_valid, a_ctrl, a_ready); end
        $display("test_flush_priority done");
    endtask

    task automatic test_stall();
        do_reset();
        rdy = 1'b1; valid = 1'b1; ctrl = 8'h05; data = 16'h5555;
        tick();
        valid = 1'b0; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_ready k=%0d: a=%b b=%b required 0/0", k, a_ready, b_ready); end
            tick();
            n_cmp++; if (a_valid !== 1'b1 || a_ctrl !== 8'h05 || b_ctrl !== 8'h05) begin
                n_err++; $display("FAIL stall_hold k=%0d: valid=%b a_ctrl=%h b_ctrl=%h required 1/05/05", k, a_valid, a_ctrl, b_ctrl); end
        end
        n_cmp++; if (a_cnt !== 4'd3 || b_cnt !== 16'd3) begin
            n_err++; $display("FAIL stall_cnt: a=%0d b=%0d required 3/3", a_cnt, b_cnt); end
        stall = 1'b0;
        tick();
        n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_cnt !== 4'd3) begin
            n_err++; $display("FAIL stall_release: a_valid=%b b_valid=%b cnt=%0d required 0/0/3", a_valid, b_valid, a_cnt); end
        $display("test_stall done");
    endtask

    task automatic test_saturation();
        do_reset();
        rdy = 1'b0; valid = 1'b1; ctrl = 8'h09; data = 16'h9999;
        tick();
        valid = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        n_cmp++; if (a_cnt !== 4'd15) begin
            n_err++; $display("FAIL sat_cnt4: cnt=%0d required 15", a_cnt); end
        n_cmp++; if (b_cnt !== 16'd20) begin
            n_err++; $display("FAIL cnt16: cnt=%0d required 20", b_cnt); end
        $display("test_saturation done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_stream();
        test_streaming();
        test_back_pressure();
        test_flush_priority();
        test_stall();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
